// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: EX-stage forwarding and load-use hazard unit.
// Keeps a shift-register scoreboard of in-flight destinations fed from the
// EX instruction. It produces a per-source forward select and a load-use
// stall request.
// Optional build macro: FWD_SCOREBOARD_PERF_EN adds the perf_clr input and
// the fwd_count and stall_count saturating event counters.
//
// Handshake: there is no valid/ready pair. ex_valid qualifies the EX
// instruction in the same cycle. load_use_stall is a same-cycle request, and
// the controller is expected to re-present the same EX instruction on the
// following cycle.
module fwd_scoreboard #(
    parameter int NUM_SRC    = 3,
    parameter int NUM_STAGES = 2,
    parameter int REG_AW     = 5,
    parameter int SEL_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fwd_en,
    input  logic                      ex_valid,
    input  logic [REG_AW-1:0]         ex_dest,
    input  logic                      ex_wb_en,
    input  logic                      ex_mem_read,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_use,
    input  logic                      hold,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
`ifdef FWD_SCOREBOARD_PERF_EN
    input  logic                      perf_clr,
    output logic [31:0]               fwd_count,
    output logic [31:0]               stall_count,
`endif
    output logic                      load_use_stall
);

    // Stage k = 1 is the youngest entry (MEM) and k = NUM_STAGES is the oldest.
    logic [NUM_STAGES:1] v_q;
    logic [REG_AW-1:0]   dest_q [1:NUM_STAGES];
    // Only a load sitting in the youngest stage can ever trigger a stall.
    // Once a load has aged past stage 1 its flag is never consulted again,
    // so older stages do not carry it.
    logic                ld_q;

    logic [NUM_STAGES:1] hit [NUM_SRC];

    // Compare each used, non-zero source address against every live entry.
    always_comb begin
        hit = '{default: '0};
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                hit[i][k] = src_use[i] && v_q[k]
                         && (dest_q[k] == src_addr[i*REG_AW +: REG_AW])
                         && (src_addr[i*REG_AW +: REG_AW] != '0);
            end
        end
    end

    // Pick the youngest matching stage per source and flag load-use hazards.
    always_comb begin
        fwd_sel        = '0;
        load_use_stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Walk from oldest to youngest so the youngest match is written last.
            for (int k = NUM_STAGES; k >= 1; k--) begin
                if (hit[i][k]) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                end
            end
            // Stage 1 is the youngest stage, so a hit there is always the winner.
            if (hit[i][1] && ld_q) begin
                load_use_stall = 1'b1;
            end
        end
        if (!fwd_en || !rst_n) begin
            fwd_sel        = '0;
            load_use_stall = 1'b0;
        end
    end

    // Advance the scoreboard unless the pipeline is frozen.
    // Stage 1 takes a bubble on flush or stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q  <= '0;
            ld_q <= 1'b0;
            for (int k = 1; k <= NUM_STAGES; k++) begin
                dest_q[k] <= '0;
            end
        end else if (!hold) begin
            for (int k = NUM_STAGES; k >= 2; k--) begin
                v_q[k]    <= v_q[k-1];
                dest_q[k] <= dest_q[k-1];
            end
            if (flush || load_use_stall) begin
                v_q[1]    <= 1'b0;
                dest_q[1] <= '0;
                ld_q      <= 1'b0;
            end else begin
                v_q[1]    <= ex_valid && ex_wb_en;
                dest_q[1] <= ex_dest;
                ld_q      <= ex_mem_read;
            end
        end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    logic any_fwd;
    assign any_fwd = |fwd_sel;

    // Saturating event counters; a synchronous clear beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else if (perf_clr) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            if (any_fwd && !hold && !load_use_stall && (fwd_count != 32'hFFFF_FFFF)) begin
                fwd_count <= fwd_count + 32'd1;
            end
            if (load_use_stall && !hold && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vector table, hand-written multi-cycle
// sequences and random stimulus for fwd_scoreboard.
module tb_fwd_scoreboard;

    localparam int NS = 3;
    localparam int NT = 2;
    localparam int AW = 5;
    localparam int SW = 2;
    localparam int W  = 1 + NS*SW;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic              fwd_en;
    logic              ex_valid;
    logic [AW-1:0]     ex_dest;
    logic              ex_wb_en;
    logic              ex_mem_read;
    logic [NS*AW-1:0]  src_addr;
    logic [NS-1:0]     src_use;
    logic              hold;
    logic              flush;
    logic [NS*SW-1:0]  fwd_sel;
    logic              load_use_stall;
`ifdef FWD_SCOREBOARD_PERF_EN
    logic              perf_clr;
    logic [31:0]       fwd_count;
    logic [31:0]       stall_count;
`endif

    fwd_scoreboard #(
        .NUM_SRC(NS), .NUM_STAGES(NT), .REG_AW(AW), .SEL_W(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fwd_en(fwd_en),
        .ex_valid(ex_valid),
        .ex_dest(ex_dest),
        .ex_wb_en(ex_wb_en),
        .ex_mem_read(ex_mem_read),
        .src_addr(src_addr),
        .src_use(src_use),
        .hold(hold),
        .flush(flush),
        .fwd_sel(fwd_sel),
`ifdef FWD_SCOREBOARD_PERF_EN
        .perf_clr(perf_clr),
        .fwd_count(fwd_count),
        .stall_count(stall_count),
`endif
        .load_use_stall(load_use_stall)
    );

    // ---------------- vectors ----------------
    typedef struct {
        logic             en;
        logic             ev;
        logic [AW-1:0]    ed;
        logic             ew;
        logic             em;
        logic [NS*AW-1:0] sa;
        logic [NS-1:0]    su;
        logic             h;
        logic             f;
        logic [NS*SW-1:0] esel;
        logic             estall;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic en, input logic ev, input int ed,
                                input logic ew, input logic em,
                                input int s0, input int s1, input int s2,
                                input logic [NS-1:0] su, input logic h, input logic f,
                                input int e0, input int e1, input int e2,
                                input logic st);
        vec_t v;
        v.en     = en;
        v.ev     = ev;
        v.ed     = ed[AW-1:0];
        v.ew     = ew;
        v.em     = em;
        v.sa     = {s2[AW-1:0], s1[AW-1:0], s0[AW-1:0]};
        v.su     = su;
        v.h      = h;
        v.f      = f;
        v.esel   = {e2[SW-1:0], e1[SW-1:0], e0[SW-1:0]};
        v.estall = st;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Index 0 of mq is the youngest in-flight instruction.
    typedef struct packed {
        logic          v;
        logic [AW-1:0] dest;
        logic          ld;
    } ent_t;

    ent_t mq[$];
    int unsigned m_fwd_cnt;
    int unsigned m_stall_cnt;

    function automatic void model_clear();
        mq.delete();
        for (int k = 0; k < NT; k++) mq.push_back('0);
    endfunction

    function automatic void model_eval(output logic [NS*SW-1:0] sel, output logic st);
        sel = '0;
        st  = 1'b0;
        for (int i = 0; i < NS; i++) begin
            logic [AW-1:0] a;
            a = src_addr[i*AW +: AW];
            if (rst_n && fwd_en && src_use[i] && a != 0) begin
                for (int j = 0; j < mq.size(); j++) begin
                    if (mq[j].v && mq[j].dest == a) begin
                        sel[i*SW +: SW] = SW'(j + 1);
                        if (j == 0 && mq[j].ld) st = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_upd
        logic [NS*SW-1:0] s;
        logic             st;
        ent_t             e;
        if (!rst_n) begin
            model_clear();
            m_fwd_cnt   = 0;
            m_stall_cnt = 0;
        end else begin
            model_eval(s, st);
`ifdef FWD_SCOREBOARD_PERF_EN
            if (perf_clr) begin
                m_fwd_cnt   = 0;
                m_stall_cnt = 0;
            end else if (!hold) begin
                if (st) m_stall_cnt++;
                else if (s != 0) m_fwd_cnt++;
            end
`endif
            if (!hold) begin
                e.v    = ex_valid && ex_wb_en && !(flush || st);
                e.dest = ex_dest;
                e.ld   = ex_mem_read;
                mq.push_front(e);
                void'(mq.pop_back());
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_tests;
    int n_fail;

    task automatic check(input string name);
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        exp_v = exp_q.pop_front();
        act_v = {load_use_stall, fwd_sel};
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got stall=%0b sel=%h, expected stall=%0b sel=%h",
                     name, act_v[W-1], act_v[W-2:0], exp_v[W-1], exp_v[W-2:0]);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act_v, exp_v);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic apply(input vec_t v);
        fwd_en      = v.en;
        ex_valid    = v.ev;
        ex_dest     = v.ed;
        ex_wb_en    = v.ew;
        ex_mem_read = v.em;
        src_addr    = v.sa;
        src_use     = v.su;
        hold        = v.h;
        flush       = v.f;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        @(posedge clk);
        #1;
        apply(v);
        @(negedge clk);
        exp_q.push_back({v.estall, v.esel});
        check(name);
    endtask

    task automatic drive_random();
        fwd_en      = ($urandom_range(0, 15) != 0);
        ex_valid    = ($urandom_range(0, 3) != 0);
        ex_dest     = AW'($urandom_range(0, 7));
        ex_wb_en    = ($urandom_range(0, 3) != 0);
        ex_mem_read = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < NS; i++) src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        src_use     = NS'($urandom_range(0, 7));
        hold        = ($urandom_range(0, 7) == 0);
        flush       = ($urandom_range(0, 7) == 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NS*SW-1:0] m_sel;
        logic             m_st;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        apply(mk(1,0,0,0,0, 0,0,0, 3'b000, 0,0, 0,0,0, 0));
`ifdef FWD_SCOREBOARD_PERF_EN
        perf_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //       en ev ed ew em  s0 s1 s2  use     h f  e0 e1 e2 st
        vq.push_back(mk(1,0, 0,0,0,  5, 0, 0, 3'b001, 0,0, 0,0,0, 0)); // empty after reset
        vq.push_back(mk(1,1, 7,1,0,  0, 0, 0, 3'b000, 0,0, 0,0,0, 0)); // r7 enters stage 1
        vq.push_back(mk(1,1,10,1,0,  7, 0, 0, 3'b001, 0,0, 1,0,0, 0)); // back-to-back -> 1
        vq.push_back(mk(1,0, 0,0,0,  7, 0, 0, 3'b001, 0,0, 2,0,0, 0)); // r7 in stage 2
        vq.push_back(mk(1,0, 0,0,0,  7, 0, 0, 3'b001, 0,0, 0,0,0, 0)); // r7 retired
        vq.push_back(mk(1,1, 9,1,0,  0, 0, 0, 3'b000, 0,0, 0,0,0, 0));
        vq.push_back(mk(1,1, 9,1,0,  0, 9, 0, 3'b010, 0,0, 0,1,0, 0));
        vq.push_back(mk(1,1, 0,1,0,  0, 9, 0, 3'b010, 0,0, 0,1,0, 0)); // r9 in both: youngest
        vq.push_back(mk(1,0, 0,0,0,  0, 0, 0, 3'b111, 0,0, 0,0,0, 0)); // r0 never forwarded
        vq.push_back(mk(1,1, 3,1,1,  0, 0, 0, 3'b000, 0,0, 0,0,0, 0)); // load r3
        vq.push_back(mk(1,1,11,1,0,  0, 0, 3, 3'b100, 0,0, 0,0,1, 1)); // load-use stall
        vq.push_back(mk(1,1,11,1,0,  0, 0, 3, 3'b100, 0,0, 0,0,2, 0)); // one cycle only
        vq.push_back(mk(1,1, 3,1,1,  0, 0, 0, 3'b000, 0,0, 0,0,0, 0)); // load r3 again
        vq.push_back(mk(1,0, 0,0,0,  0, 0, 3, 3'b000, 0,0, 0,0,0, 0)); // masked: no stall
        vq.push_back(mk(1,1, 6,1,0,  0, 0, 0, 3'b000, 0,0, 0,0,0, 0));
        vq.push_back(mk(1,1, 6,1,1,  6, 0, 0, 3'b001, 0,0, 1,0,0, 0)); // non-load in stage 1
        vq.push_back(mk(1,0, 0,0,0,  6, 0, 0, 3'b001, 0,0, 1,0,0, 1)); // load youngest: stall
        vq.push_back(mk(1,0, 0,0,0,  6, 0, 0, 3'b001, 0,0, 2,0,0, 0));
        vq.push_back(mk(1,1, 8,1,1,  0, 0, 0, 3'b000, 0,0, 0,0,0, 0));
        vq.push_back(mk(1,1,12,1,0,  0, 8, 0, 3'b010, 0,1, 0,1,0, 1)); // flush + stall
        vq.push_back(mk(1,0, 0,0,0,  8,12, 0, 3'b011, 0,0, 2,0,0, 0)); // single bubble
        vq.push_back(mk(1,1, 5,1,1,  0, 0, 0, 3'b000, 0,0, 0,0,0, 0));
        vq.push_back(mk(0,1, 5,1,0,  5, 0, 0, 3'b001, 0,0, 0,0,0, 0)); // fwd_en = 0
        vq.push_back(mk(1,0, 0,0,0,  5, 5, 0, 3'b011, 0,0, 1,1,0, 0));
        vq.push_back(mk(1,0, 0,0,0,  5, 0, 0, 3'b001, 0,0, 2,0,0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], $sformatf("vec%0d", i));
        end

        // hold freezes the scoreboard
        run_vec(mk(1,1, 7,1,0,  0,0,0, 3'b000, 0,0, 0,0,0, 0), "hold_setup");
        for (int c = 0; c < 3; c++) begin
            run_vec(mk(1,1, 2,1,0,  7,0,0, 3'b001, 1,0, 1,0,0, 0), $sformatf("hold%0d", c));
        end
        run_vec(mk(1,1, 2,1,0,  7,0,0, 3'b001, 0,0, 1,0,0, 0), "hold_release");
        run_vec(mk(1,0, 0,0,0,  7,0,0, 3'b001, 0,0, 2,0,0, 0), "hold_advance");
        // hold overrides the stall bubble
        run_vec(mk(1,1,13,1,1,  0,0,0, 3'b000, 0,0, 0,0,0, 0), "hstall_load");
        run_vec(mk(1,1,14,1,0, 13,0,0, 3'b001, 1,0, 1,0,0, 1), "hstall_held");
        run_vec(mk(1,1,14,1,0, 13,0,0, 3'b001, 0,0, 1,0,0, 1), "hstall_stall");
        run_vec(mk(1,1,14,1,0, 13,0,0, 3'b001, 0,0, 2,0,0, 0), "hstall_after");
        // flush kills the EX write
        run_vec(mk(1,1, 4,1,0,  0,0,0, 3'b000, 0,1, 0,0,0, 0), "flush_r4");
        run_vec(mk(1,0, 0,0,0,  4,0,0, 3'b001, 0,0, 0,0,0, 0), "flush_s1");
        run_vec(mk(1,0, 0,0,0,  4,0,0, 3'b001, 0,0, 0,0,0, 0), "flush_s2");
        // hold overrides flush
        run_vec(mk(1,1,15,1,0,  0,0,0, 3'b000, 0,0, 0,0,0, 0), "hflush_setup");
        run_vec(mk(1,1, 4,1,0, 15,0,0, 3'b001, 1,1, 1,0,0, 0), "hflush_held");
        run_vec(mk(1,0, 0,0,0, 15,0,0, 3'b001, 0,0, 1,0,0, 0), "hflush_kept");

        // reset mid-stream with live entries
        run_vec(mk(1,1, 5,1,0,  0,0,0, 3'b000, 0,0, 0,0,0, 0), "rst_fill0");
        run_vec(mk(1,1, 5,1,0,  5,0,0, 3'b001, 0,0, 1,0,0, 0), "rst_fill1");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        apply(mk(1,1, 5,1,0,  5,0,0, 3'b001, 0,0, 0,0,0, 0));
        @(negedge clk);
        exp_q.push_back('0);
        check("reset_active");
        #1 rst_n = 1'b1;
        #1;
        exp_q.push_back('0);
        check("reset_first_cycle");

        // random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            drive_random();
            @(negedge clk);
            model_eval(m_sel, m_st);
            exp_q.push_back({m_st, m_sel});
            check($sformatf("rand%0d", c));
        end

`ifdef FWD_SCOREBOARD_PERF_EN
        @(posedge clk);
        #1;
        apply(mk(0,0,0,0,0, 0,0,0, 3'b000, 0,0, 0,0,0, 0));
        @(negedge clk);
        check_val("fwd_count", fwd_count, m_fwd_cnt);
        check_val("stall_count", stall_count, m_stall_cnt);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        check_val("fwd_count_clr", fwd_count, 32'd0);
        check_val("stall_count_clr", stall_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
